// File: rtl/video_dram_arb_pkg.sv
// Shared definitions for the video/CPU DRAM arbiter: cycle-type encoding,
// phase count and refresh defaults.
package video_dram_arb_pkg;

    typedef enum logic [1:0] {
        CycIdle  = 2'd0,
        CycVideo = 2'd1,
        CycCpu   = 2'd2,
        CycRfsh  = 2'd3
    } cyc_e;

    localparam int unsigned NumPhases     = 4;
    localparam int unsigned DefRfshPeriod = 96;
    localparam int unsigned StarveWraps   = 4;
    localparam int unsigned AddrW         = 21;
    localparam int unsigned DataW         = 16;

endpackage

// File: rtl/dram_rfsh_timer.sv
// Refresh interval timer with a single pending bit and a starvation counter
// that forces refresh when video keeps the bus busy.
module dram_rfsh_timer
    import video_dram_arb_pkg::*;
#(
    parameter int unsigned RFSH_PERIOD = DefRfshPeriod
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_grant,
    output logic o_pending,
    output logic o_force
);

    logic [7:0] r_cnt;
    logic       r_pending;
    logic [2:0] r_starve;
    logic       w_wrap;

    assign w_wrap = i_tick && (r_cnt == 8'(RFSH_PERIOD - 1));

    // r_starve counts wraps since the pending refresh was raised, including the raising wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 8'd0;
            r_pending <= 1'b0;
            r_starve  <= 3'd0;
        end else begin
            if (i_tick) begin
                r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
            end
            if (i_grant) begin
                r_pending <= 1'b0;
                r_starve  <= 3'd0;
            end else if (w_wrap) begin
                r_pending <= 1'b1;
                if (r_starve != 3'(StarveWraps)) begin
                    r_starve <= r_starve + 3'd1;
                end
            end
        end
    end

    assign o_pending = r_pending;
    assign o_force   = r_pending && (r_starve == 3'(StarveWraps));

endmodule

// File: rtl/video_dram_arb.sv
// Four-phase DRAM arbiter sharing one DRAM between a video fetcher, a CPU
// port and periodic refresh.
module video_dram_arb
    import video_dram_arb_pkg::*;
#(
    parameter int unsigned RFSH_PERIOD = DefRfshPeriod
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             video_req,
    input  logic [AddrW-1:0] video_addr,
    output logic             video_next,
    output logic             video_strobe,
    output logic [DataW-1:0] video_data,
    input  logic             cpu_req,
    input  logic [AddrW-1:0] cpu_addr,
    input  logic             cpu_rnw,
    input  logic [DataW-1:0] cpu_wrdata,
    input  logic [1:0]       cpu_bsel,
    output logic             cpu_next,
    output logic             cpu_strobe,
    output logic [DataW-1:0] cpu_rddata,
    output logic [AddrW-1:0] dram_addr,
    output logic             dram_cs,
    output logic             dram_we,
    output logic [1:0]       dram_bsel,
    output logic [DataW-1:0] dram_wrdata,
    output logic             dram_rfsh,
    input  logic [DataW-1:0] dram_rddata
);

    logic [1:0]       r_phase;
    cyc_e             r_cyc;
    logic [AddrW-1:0] r_addr;
    logic             r_cs;
    logic             r_we;
    logic [1:0]       r_bsel;
    logic [DataW-1:0] r_wrdata;
    logic             r_rfsh;
    logic             r_vstb;
    logic [DataW-1:0] r_vdata;
    logic             r_cstb;
    logic [DataW-1:0] r_cdata;

    cyc_e             w_grant;
    logic             w_ph0;
    logic             w_ph3;
    logic             w_pending;
    logic             w_force;

    assign w_ph0 = (r_phase == 2'd0);
    assign w_ph3 = (r_phase == 2'(NumPhases - 1));

    dram_rfsh_timer #(
        .RFSH_PERIOD (RFSH_PERIOD)
    ) u_rfsh_timer (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (w_ph3),
        .i_grant   (w_grant == CycRfsh),
        .o_pending (w_pending),
        .o_force   (w_force)
    );

    // Grant is only non-idle in phase 0; rst gates it so no next pulse leaks out.
    always_comb begin
        w_grant = CycIdle;
        if (w_ph0 && !rst) begin
            if (w_force) begin
                w_grant = CycRfsh;
            end else if (video_req) begin
                w_grant = CycVideo;
            end else if (w_pending) begin
                w_grant = CycRfsh;
            end else if (cpu_req) begin
                w_grant = CycCpu;
            end
        end
    end

    assign video_next = (w_grant == CycVideo);
    assign cpu_next   = (w_grant == CycCpu);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= 2'd0;
            r_cyc    <= CycIdle;
            r_addr   <= '0;
            r_cs     <= 1'b0;
            r_we     <= 1'b0;
            r_bsel   <= 2'b00;
            r_wrdata <= '0;
            r_rfsh   <= 1'b0;
            r_vstb   <= 1'b0;
            r_vdata  <= '0;
            r_cstb   <= 1'b0;
            r_cdata  <= '0;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_cs    <= 1'b0;
            r_rfsh  <= 1'b0;
            r_vstb  <= 1'b0;
            r_cstb  <= 1'b0;

            // Bus fields change only here, so they hold through phase 3.
            if (w_ph0) begin
                r_cyc <= w_grant;
                unique case (w_grant)
                    CycVideo: begin
                        r_addr <= video_addr;
                        r_we   <= 1'b0;
                        r_bsel <= 2'b11;
                        r_cs   <= 1'b1;
                    end
                    CycCpu: begin
                        r_addr   <= cpu_addr;
                        r_we     <= !cpu_rnw;
                        r_bsel   <= cpu_bsel;
                        r_wrdata <= cpu_wrdata;
                        r_cs     <= 1'b1;
                    end
                    CycRfsh: begin
                        r_we   <= 1'b0;
                        r_rfsh <= 1'b1;
                    end
                    CycIdle: begin
                        r_we <= 1'b0;
                    end
                endcase
            end

            if (w_ph3) begin
                if (r_cyc == CycVideo) begin
                    r_vdata <= dram_rddata;
                    r_vstb  <= 1'b1;
                end
                if ((r_cyc == CycCpu) && !r_we) begin
                    r_cdata <= dram_rddata;
                    r_cstb  <= 1'b1;
                end
            end
        end
    end

    assign dram_addr    = r_addr;
    assign dram_cs      = r_cs;
    assign dram_we      = r_we;
    assign dram_bsel    = r_bsel;
    assign dram_wrdata  = r_wrdata;
    assign dram_rfsh    = r_rfsh;
    assign video_strobe = r_vstb;
    assign video_data   = r_vdata;
    assign cpu_strobe   = r_cstb;
    assign cpu_rddata   = r_cdata;

endmodule

// File: tb/tb_video_dram_arb.sv
// Directed bench for video_dram_arb with RFSH_PERIOD=4; k counts clocks since
// reset release, so phase = k % 4.
module tb_video_dram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        video_req;
    logic [20:0] video_addr;
    logic        video_next;
    logic        video_strobe;
    logic [15:0] video_data;
    logic        cpu_req;
    logic [20:0] cpu_addr;
    logic        cpu_rnw;
    logic [15:0] cpu_wrdata;
    logic [1:0]  cpu_bsel;
    logic        cpu_next;
    logic        cpu_strobe;
    logic [15:0] cpu_rddata;
    logic [20:0] dram_addr;
    logic        dram_cs;
    logic        dram_we;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata;
    logic        dram_rfsh;
    logic [15:0] dram_rddata;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    always #5 clk = ~clk;

    video_dram_arb #(
        .RFSH_PERIOD (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .video_req    (video_req),
        .video_addr   (video_addr),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_rnw      (cpu_rnw),
        .cpu_wrdata   (cpu_wrdata),
        .cpu_bsel     (cpu_bsel),
        .cpu_next     (cpu_next),
        .cpu_strobe   (cpu_strobe),
        .cpu_rddata   (cpu_rddata),
        .dram_addr    (dram_addr),
        .dram_cs      (dram_cs),
        .dram_we      (dram_we),
        .dram_bsel    (dram_bsel),
        .dram_wrdata  (dram_wrdata),
        .dram_rfsh    (dram_rfsh),
        .dram_rddata  (dram_rddata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic idle_inputs();
        video_req   = 1'b0;
        video_addr  = '0;
        cpu_req     = 1'b0;
        cpu_addr    = '0;
        cpu_rnw     = 1'b0;
        cpu_wrdata  = '0;
        cpu_bsel    = 2'b00;
        dram_rddata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vnext"}, 32'(video_next), 32'h0);
        check_eq({tag, "_vstb"}, 32'(video_strobe), 32'h0);
        check_eq({tag, "_vdata"}, 32'(video_data), 32'h0);
        check_eq({tag, "_cnext"}, 32'(cpu_next), 32'h0);
        check_eq({tag, "_cstb"}, 32'(cpu_strobe), 32'h0);
        check_eq({tag, "_cdata"}, 32'(cpu_rddata), 32'h0);
        check_eq({tag, "_addr"}, 32'(dram_addr), 32'h0);
        check_eq({tag, "_cs"}, 32'(dram_cs), 32'h0);
        check_eq({tag, "_we"}, 32'(dram_we), 32'h0);
        check_eq({tag, "_bsel"}, 32'(dram_bsel), 32'h0);
        check_eq({tag, "_wrdata"}, 32'(dram_wrdata), 32'h0);
        check_eq({tag, "_rfsh"}, 32'(dram_rfsh), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vn_cnt;
        int rf_cnt;
        int cs_cnt;
        int both_cnt;
        int bad_next;
        int cn_cnt;
        int cs_stb;

        // Video fetch latency, then held video_req forcing one refresh.
        do_reset();
        video_req   = 1'b1;
        video_addr  = 21'h0A000;
        dram_rddata = 16'hBEEF;
        #1;
        vn_cnt = 0; rf_cnt = 0; cs_cnt = 0; both_cnt = 0; bad_next = 0;
        for (int i = 0; i < 80; i++) begin
            if (i > 0) step();
            if (video_next) begin
                if ((k % 4) == 0) vn_cnt++;
                else bad_next++;
            end
            if (dram_rfsh) rf_cnt++;
            if (dram_cs) cs_cnt++;
            if (dram_rfsh && dram_cs) both_cnt++;
            if (k == 0) check_eq("vid_next_T", 32'(video_next), 32'h1);
            if (k == 1) begin
                check_eq("vid_addr_T1", 32'(dram_addr), 32'h0A000);
                check_eq("vid_cs_T1", 32'(dram_cs), 32'h1);
                check_eq("vid_we_T1", 32'(dram_we), 32'h0);
                check_eq("vid_bsel_T1", 32'(dram_bsel), 32'h3);
            end
            if (k == 2) check_eq("vid_cs_T2", 32'(dram_cs), 32'h0);
            if (k == 3) check_eq("vid_stb_T3", 32'(video_strobe), 32'h0);
            if (k == 4) begin
                check_eq("vid_stb_T4", 32'(video_strobe), 32'h1);
                check_eq("vid_data_T4", 32'(video_data), 32'hBEEF);
            end
            if (k == 5) begin
                check_eq("vid_stb_T5", 32'(video_strobe), 32'h0);
                check_eq("vid_data_hold", 32'(video_data), 32'hBEEF);
            end
            if (k == 64) check_eq("force_vnext_gap", 32'(video_next), 32'h0);
            if (k == 65) check_eq("force_rfsh", 32'(dram_rfsh), 32'h1);
            if (k == 68) check_eq("force_vnext_back", 32'(video_next), 32'h1);
        end
        check_eq("force_vnext_cnt", 32'(vn_cnt), 32'd19);
        check_eq("force_rfsh_cnt", 32'(rf_cnt), 32'd1);
        check_eq("force_cs_cnt", 32'(cs_cnt), 32'd19);
        check_eq("cs_rfsh_both", 32'(both_cnt), 32'd0);
        check_eq("vnext_off_ph0", 32'(bad_next), 32'd0);

        // Reset with traffic on the bus; video_req kept high to test next gating.
        rst = 1'b1;
        step();
        step();
        check_all_zero("rst");
        rst       = 1'b0;
        video_req = 1'b0;

        // Idle bus: refresh every 4 DRAM cycles.
        do_reset();
        #1;
        rf_cnt = 0; cs_cnt = 0; vn_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) step();
            if (dram_rfsh) rf_cnt++;
            if (dram_cs) cs_cnt++;
            if (video_next || cpu_next) vn_cnt++;
            if (k == 17) check_eq("idle_rfsh_17", 32'(dram_rfsh), 32'h1);
            if (k == 33) check_eq("idle_rfsh_33", 32'(dram_rfsh), 32'h1);
        end
        check_eq("idle_rfsh_cnt", 32'(rf_cnt), 32'd2);
        check_eq("idle_cs_cnt", 32'(cs_cnt), 32'd0);
        check_eq("idle_next_cnt", 32'(vn_cnt), 32'd0);

        // CPU reads held: refresh preempts exactly one cycle.
        do_reset();
        cpu_req     = 1'b1;
        cpu_rnw     = 1'b1;
        cpu_addr    = 21'h0ABCD;
        cpu_bsel    = 2'b11;
        dram_rddata = 16'h1357;
        #1;
        cn_cnt = 0; cs_stb = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            if (cpu_next) cn_cnt++;
            if (cpu_strobe) cs_stb++;
            if (k == 1) begin
                check_eq("crd_addr", 32'(dram_addr), 32'h0ABCD);
                check_eq("crd_we", 32'(dram_we), 32'h0);
                check_eq("crd_cs", 32'(dram_cs), 32'h1);
            end
            if (k == 4) begin
                check_eq("crd_stb", 32'(cpu_strobe), 32'h1);
                check_eq("crd_data", 32'(cpu_rddata), 32'h1357);
            end
            if (k == 16) check_eq("crd_preempt", 32'(cpu_next), 32'h0);
            if (k == 17) check_eq("crd_rfsh", 32'(dram_rfsh), 32'h1);
            if (k == 20) begin
                check_eq("crd_resume", 32'(cpu_next), 32'h1);
                check_eq("crd_no_stb_rfsh", 32'(cpu_strobe), 32'h0);
            end
        end
        check_eq("crd_next_cnt", 32'(cn_cnt), 32'd5);
        check_eq("crd_stb_cnt", 32'(cs_stb), 32'd4);

        // CPU byte write: no strobe, bus fields held through T+4.
        do_reset();
        cpu_req     = 1'b1;
        cpu_rnw     = 1'b0;
        cpu_addr    = 21'h01234;
        cpu_wrdata  = 16'h55AA;
        cpu_bsel    = 2'b01;
        dram_rddata = 16'hFFFF;
        #1;
        check_eq("cwr_next", 32'(cpu_next), 32'h1);
        cs_stb = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (k == 1) begin
                cpu_req = 1'b0;
                #1;
                check_eq("cwr_cs", 32'(dram_cs), 32'h1);
                check_eq("cwr_addr", 32'(dram_addr), 32'h01234);
                check_eq("cwr_wrdata", 32'(dram_wrdata), 32'h55AA);
            end
            if (cpu_strobe) cs_stb++;
            if (k <= 4) begin
                check_eq("cwr_we", 32'(dram_we), 32'h1);
                check_eq("cwr_bsel", 32'(dram_bsel), 32'h1);
            end
            if (k == 4) check_eq("cwr_no_next", 32'(cpu_next), 32'h0);
        end
        check_eq("cwr_stb_cnt", 32'(cs_stb), 32'd0);
        check_eq("cwr_rddata", 32'(cpu_rddata), 32'h0);

        // Video beats CPU until video_req drops.
        do_reset();
        video_req  = 1'b1;
        video_addr = 21'h00100;
        cpu_req    = 1'b1;
        cpu_rnw    = 1'b1;
        cpu_addr   = 21'h00200;
        cpu_bsel   = 2'b11;
        #1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) step();
            if (k == 9) begin
                video_req = 1'b0;
                #1;
            end
            if (k == 0 || k == 4 || k == 8) begin
                check_eq("both_vnext", 32'(video_next), 32'h1);
                check_eq("both_cnext", 32'(cpu_next), 32'h0);
            end
            if (k == 12) begin
                check_eq("both_cpu_grant", 32'(cpu_next), 32'h1);
                check_eq("both_vid_off", 32'(video_next), 32'h0);
            end
        end

        // Reset in phase 2 of a video cycle aborts it.
        do_reset();
        video_req   = 1'b1;
        video_addr  = 21'h0A000;
        dram_rddata = 16'hBEEF;
        #1;
        check_eq("abort_vnext_T", 32'(video_next), 32'h1);
        step();
        step();
        rst = 1'b1;
        step();
        check_all_zero("abort");
        step();
        check_eq("abort_no_stb", 32'(video_strobe), 32'h0);
        check_eq("abort_vnext_rst", 32'(video_next), 32'h0);
        rst = 1'b0;
        k   = 0;
        #1;
        check_eq("abort_resume", 32'(video_next), 32'h1);
        repeat (4) step();
        check_eq("abort_stb", 32'(video_strobe), 32'h1);
        check_eq("abort_data", 32'(video_data), 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_dram_arb.md
VIDEO_DRAM_ARB -- requirements
Module: video_dram_arb

Interface
REQ-001 SHALL have parameter RFSH_PERIOD, default 96, meaning DRAM cycles between refresh requests (range 4..255).
REQ-002 SHALL have port clk  input  1  28 MHz clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port video_req  input  1  level; video fetch window active.
REQ-005 SHALL have port video_addr  input  21  word address of next video fetch, held stable until video_next.
REQ-006 SHALL have port video_next  output  1  one-clk pulse; video_addr accepted, producer advances.
REQ-007 SHALL have port video_strobe  output  1  one-clk pulse; video_data valid.
REQ-008 SHALL have port video_data  output  16  fetched video word.
REQ-009 SHALL have ports cpu_req in 1, cpu_addr in 21, cpu_rnw in 1, cpu_wrdata in 16, cpu_bsel in 2 (byte enables); CPU request, held until cpu_next.
REQ-010 SHALL have ports cpu_next out 1 (request accepted), cpu_strobe out 1 (read data valid), cpu_rddata out 16.
REQ-011 SHALL have ports dram_addr out 21, dram_cs out 1, dram_we out 1, dram_bsel out 2, dram_wrdata out 16, dram_rfsh out 1, dram_rddata in 16.

Function
REQ-012 SHALL run a free 2-bit phase counter; one DRAM cycle = phases 0..3 = 4 clocks.
REQ-013 SHALL arbitrate only in phase 0; priority video > pending refresh > cpu > idle.
REQ-014 SHALL assert video_next (resp. cpu_next) combinationally during the phase-0 clock of a granted cycle only; never outside phase 0.
REQ-015 SHALL register dram_addr/dram_we/dram_bsel/dram_wrdata at end of phase 0 and hold them through phase 3.
REQ-016 SHALL pulse dram_cs in phase 1 for video and cpu cycles; dram_rfsh in phase 1 for refresh cycles; never both.
REQ-017 Video cycles SHALL be reads with dram_bsel=2'b11, dram_we=0.
REQ-018 SHALL sample dram_rddata at end of phase 3; latency grant (T) -> video_strobe/cpu_strobe with data at T+4 (next phase 0).
REQ-019 cpu_strobe SHALL pulse only for cpu_rnw=1 cycles; writes produce no strobe.
REQ-020 SHALL count DRAM cycles; on reaching RFSH_PERIOD set rfsh_pending and restart count; clear pending when refresh cycle granted.
REQ-021 Counter wrap while rfsh_pending already set SHALL not queue a second refresh (single pending bit).
REQ-022 If video_req holds continuously, refresh SHALL be forced anyway once pending for 4 consecutive RFSH_PERIOD wraps, overriding video for one cycle.
REQ-023 video_data/cpu_rddata SHALL hold last value between strobes.

Reset
REQ-024 rst SHALL set phase=0, cycle type=idle, refresh count=0, rfsh_pending=0, starvation count=0.
REQ-025 rst SHALL drive all outputs to 0 (including data and address buses) on the next clock.
REQ-026 rst mid-cycle SHALL abort the cycle with no strobe or next emitted.

Structure
REQ-027 Shared package SHALL hold cycle-type encoding (IDLE, VIDEO, CPU, RFSH), phase count 4, default RFSH_PERIOD.
REQ-028 Refresh timer plus starvation counter SHALL be a sub-module dram_rfsh_timer.

Verification
REQ-029 video_req=1, video_addr=21'h0A000 -> video_next at phase 0 (T); dram_addr=21'h0A000, dram_cs at T+1; video_strobe with dram_rddata 16'hBEEF at T+4.
REQ-030 video_req and cpu_req both asserted -> video granted every cycle; cpu_next stays 0 until video_req drops, then granted at next phase 0.
REQ-031 cpu write cpu_addr=21'h01234, cpu_wrdata=16'h55AA, bsel=2'b01 -> dram_we=1, dram_bsel=2'b01 at T+1..T+4, no cpu_strobe.
REQ-032 RFSH_PERIOD=4, idle bus -> dram_rfsh pulse every 4 DRAM cycles (every 16 clocks); with cpu_req held, refresh preempts cpu once.
REQ-033 RFSH_PERIOD=4, video_req held -> forced refresh after 4 wraps pending; video_next missing exactly one phase 0.
REQ-034 rst asserted in phase 2 of a video cycle -> no video_strobe; all outputs 0 next clock; arbitration resumes at phase 0 after release.
